// File: rtl/req_sched_64.sv
// Request scheduler: captures rising edges on 64 request lines, masks them,
// and hands out one 6-bit grant at a time through a valid/ready handshake.
module req_sched_64 #(
  parameter bit RR = 1'b0,
  parameter int N  = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         mask_we,
  input  logic [N-1:0] mask_data,
  input  logic         gnt_ready,
  input  logic         done,
  output logic         gnt_valid,
  output logic [5:0]   gnt_id,
  output logic         busy,
  output logic         any_pending
);

  typedef enum logic [1:0] {IDLE, ARB, OFFER, BUSY} state_t;

  state_t       state;
  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic [N-1:0] req_d;
  logic [5:0]   rr_ptr;

  logic [N-1:0] elig;
  logic [N-1:0] clr;
  logic [N-1:0] pending_n;
  logic [N-1:0] mask_n;
  logic         accept;
  logic [5:0]   winner;
  logic [5:0]   start;
  logic [5:0]   idx;
  logic         found;

  assign elig   = pending & ~mask;
  assign accept = (state == OFFER) && gnt_ready;
  assign mask_n = mask_we ? mask_data : mask;

  // A new edge is OR-ed in after the accept clear, so a same-cycle re-request survives.
  always_comb begin
    clr = '0;
    if (accept) clr[gnt_id] = 1'b1;
    pending_n = (pending & ~clr) | (req & ~req_d);
  end

  // Scan from the start point upward with 6-bit wraparound; first eligible line wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    start  = RR ? rr_ptr : 6'd0;
    for (int i = 0; i < N; i++) begin
      idx = start + 6'(i);
      if (!found && elig[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      mask        <= '0;
      req_d       <= '0;
      rr_ptr      <= '0;
      gnt_valid   <= 1'b0;
      gnt_id      <= '0;
      busy        <= 1'b0;
      any_pending <= 1'b0;
    end else begin
      pending     <= pending_n;
      mask        <= mask_n;
      req_d       <= req;
      any_pending <= |(pending_n & ~mask_n);
      case (state)
        IDLE: begin
          if (elig != '0) state <= ARB;
        end
        ARB: begin
          if (found) begin
            gnt_id    <= winner;
            gnt_valid <= 1'b1;
            state     <= OFFER;
          end else begin
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        OFFER: begin
          if (gnt_ready) begin
            gnt_valid <= 1'b0;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            busy   <= 1'b0;
            rr_ptr <= gnt_id + 6'd1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_sched_64.sv
// Bench for req_sched_64: fixed-priority and round-robin instances share one
// stimulus stream and are both checked every cycle against a reference model.
module tb_req_sched_64;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] req;
  logic        mask_we;
  logic [63:0] mask_data;
  logic        gnt_ready;
  logic        done;
  logic [1:0]  gv, bsy, anyp;
  logic [5:0]  gid0, gid1;

  int compared = 0;
  int mismatched = 0;

  localparam int P_IDLE = 0, P_ARB = 1, P_OFFER = 2, P_BUSY = 3;

  logic [63:0] m_pend [2];
  logic [63:0] m_mask [2];
  logic [63:0] m_reqd [2];
  int          m_ptr  [2];
  int          m_phase[2];
  int          m_gid  [2];
  logic        m_gv   [2];
  logic        m_busy [2];
  logic        m_any  [2];

  always #5 clk = ~clk;

  req_sched_64 #(.RR(1'b0), .N(64)) u0 (
    .clk(clk), .reset(reset), .req(req), .mask_we(mask_we), .mask_data(mask_data),
    .gnt_ready(gnt_ready), .done(done), .gnt_valid(gv[0]), .gnt_id(gid0),
    .busy(bsy[0]), .any_pending(anyp[0])
  );

  req_sched_64 #(.RR(1'b1), .N(64)) u1 (
    .clk(clk), .reset(reset), .req(req), .mask_we(mask_we), .mask_data(mask_data),
    .gnt_ready(gnt_ready), .done(done), .gnt_valid(gv[1]), .gnt_id(gid1),
    .busy(bsy[1]), .any_pending(anyp[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour for one clock edge, from the current inputs and model state.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      logic [63:0] elig, np, nm;
      int start, w;
      bit found;
      if (reset) begin
        m_pend[m] = '0; m_mask[m] = '0; m_reqd[m] = '0; m_ptr[m] = 0;
        m_phase[m] = P_IDLE; m_gv[m] = 0; m_gid[m] = 0; m_busy[m] = 0; m_any[m] = 0;
      end else begin
        elig = m_pend[m] & ~m_mask[m];
        np = m_pend[m];
        for (int i = 0; i < 64; i++) begin
          if (m_phase[m] == P_OFFER && gnt_ready && m_gid[m] == i) np[i] = 1'b0;
          if (req[i] && !m_reqd[m][i]) np[i] = 1'b1;
        end
        nm = mask_we ? mask_data : m_mask[m];
        case (m_phase[m])
          P_IDLE: if (elig != 0) m_phase[m] = P_ARB;
          P_ARB: begin
            start = (m == 1) ? m_ptr[m] : 0;
            found = 0; w = 0;
            for (int k = 0; k < 64; k++)
              if (!found && elig[(start + k) % 64]) begin w = (start + k) % 64; found = 1; end
            if (found) begin m_gid[m] = w; m_gv[m] = 1; m_phase[m] = P_OFFER; end
            else begin m_gv[m] = 0; m_phase[m] = P_IDLE; end
          end
          P_OFFER: if (gnt_ready) begin m_gv[m] = 0; m_busy[m] = 1; m_phase[m] = P_BUSY; end
          default: if (done) begin m_busy[m] = 0; m_ptr[m] = (m_gid[m] + 1) % 64; m_phase[m] = P_IDLE; end
        endcase
        m_pend[m] = np; m_mask[m] = nm; m_reqd[m] = req;
        m_any[m] = ((np & ~nm) != 0);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("gv_fixed", gv[0], m_gv[0]);
    chk("gv_rr", gv[1], m_gv[1]);
    chk("gid_fixed", gid0, m_gid[0]);
    chk("gid_rr", gid1, m_gid[1]);
    chk("busy_fixed", bsy[0], m_busy[0]);
    chk("busy_rr", bsy[1], m_busy[1]);
    chk("anyp_fixed", anyp[0], m_any[0]);
    chk("anyp_rr", anyp[1], m_any[1]);
  endtask

  task automatic do_reset();
    req = '0; mask_we = 0; mask_data = '0; gnt_ready = 0; done = 0;
    reset = 1; step(); reset = 0;
  endtask

  // From IDLE with eligible work: ARB, OFFER (checked), accept, done.
  task automatic serve(input int exp0, input int exp1, input string tag);
    gnt_ready = 1;
    step();
    chk({tag, "_arb_gv"}, gv, 2'b00);
    step();
    chk({tag, "_offer_gv"}, gv, 2'b11);
    chk({tag, "_gid_fixed"}, gid0, exp0);
    chk({tag, "_gid_rr"}, gid1, exp1);
    step();
    chk({tag, "_busy"}, bsy, 2'b11);
    chk({tag, "_gv_off"}, gv, 2'b00);
    done = 1; step(); done = 0;
    chk({tag, "_done_busy"}, bsy, 2'b00);
  endtask

  initial begin
    reset = 1; req = '0; mask_we = 0; mask_data = '0; gnt_ready = 0; done = 0;
    @(negedge clk);
    do_reset();
    chk("reset_gv", gv, 2'b00);
    chk("reset_busy", bsy, 2'b00);
    chk("reset_anyp", anyp, 2'b00);
    chk("reset_gid", {gid1, gid0}, 12'h000);

    // Simultaneous edges on 5 and 40.
    req[5] = 1; req[40] = 1;
    step();
    serve(5, 5, "s1a");
    serve(40, 40, "s1b");
    chk("s1_anyp", anyp, 2'b00);

    // Lines 0, 1, 63 then a re-pend of 0 wrapping past 63.
    do_reset();
    req[0] = 1; req[1] = 1; req[63] = 1;
    step();
    req = '0;
    serve(0, 0, "s2a");
    serve(1, 1, "s2b");
    serve(63, 63, "s2c");
    req[0] = 1;
    step();
    serve(0, 0, "s2d");

    // Masked line 7 stays silent until unmasked.
    do_reset();
    mask_we = 1; mask_data = 64'd1 << 7;
    step();
    mask_we = 0; req[7] = 1;
    for (int i = 0; i < 5; i++) step();
    chk("s3_gv_masked", gv, 2'b00);
    chk("s3_anyp_masked", anyp, 2'b00);
    mask_we = 1; mask_data = '0;
    step();
    mask_we = 0;
    serve(7, 7, "s3");

    // Offer on 12 held while 12 and 3 get masked.
    do_reset();
    req[12] = 1;
    step(); step(); step();
    chk("s4_offer_gid", gid0, 12);
    req[3] = 1; mask_we = 1; mask_data = (64'd1 << 12) | (64'd1 << 3);
    step();
    mask_we = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("s4_hold_gv", gv, 2'b11);
      chk("s4_hold_gid", {gid1, gid0}, {6'd12, 6'd12});
    end
    chk("s4_anyp", anyp, 2'b00);
    gnt_ready = 1;
    step();
    chk("s4_busy", bsy, 2'b11);
    done = 1; step(); done = 0;

    // Accept of 9 coincides with a fresh edge on 9.
    do_reset();
    req[9] = 1;
    step();
    req[9] = 0;
    step(); step();
    chk("s5_offer_gid", gid1, 9);
    req[9] = 1; gnt_ready = 1;
    step();
    chk("s5_busy", bsy, 2'b11);
    chk("s5_still_pending", anyp, 2'b11);
    done = 1; step(); done = 0;
    serve(9, 9, "s5");

    // Reset during BUSY with four queued lines.
    do_reset();
    req[2] = 1;
    step();
    gnt_ready = 1;
    step(); step(); step();
    chk("s6_busy", bsy, 2'b11);
    req = (64'd1 << 2) | (64'd1 << 10) | (64'd1 << 20) | (64'd1 << 30) | (64'd1 << 40);
    step();
    chk("s6_queued", anyp, 2'b11);
    req = '0; reset = 1;
    step();
    reset = 0;
    chk("s6_rst_busy", bsy, 2'b00);
    chk("s6_rst_gv", gv, 2'b00);
    chk("s6_rst_anyp", anyp, 2'b00);
    done = 1; step(); done = 0;
    chk("s6_done_ignored", bsy, 2'b00);
    for (int i = 0; i < 3; i++) step();
    chk("s6_idle_gv", gv, 2'b00);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) req[$urandom_range(63)] ^= 1'b1;
      if ($urandom_range(9) == 0) req[$urandom_range(63)] ^= 1'b1;
      mask_we = ($urandom_range(39) == 0);
      mask_data = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      gnt_ready = $urandom_range(1);
      done = ($urandom_range(3) == 0);
      reset = ($urandom_range(499) == 0);
      step();
    end
    reset = 0; done = 0; mask_we = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
